// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side drain engine.
//   FIFO_WIDTH : default data width, matching the async_fifo word width
//   BUF_DEPTH  : number of words the stream-side buffer can hold
//   calc_space : free buffer slots once this cycle's fire is accounted for
package fifo_rd_stream_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int BUF_DEPTH  = 2;

  // occ + infl never exceeds BUF_DEPTH, so the subtraction cannot underflow.
  function automatic logic [2:0] calc_space(input logic [1:0] occ,
                                            input logic       infl,
                                            input logic       fire);
    return 3'(BUF_DEPTH) - {1'b0, occ} - {2'b00, infl} + {2'b00, fire};
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry ordered buffer sitting between the FIFO read data and the stream.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_wr_en        : enqueue i_wr_data behind the current contents
//   i_wr_data      : word to enqueue
//   i_rd_en        : drop the head word (ignored when empty)
//   o_head_data    : oldest buffered word
//   o_occ          : number of buffered words (0..2)
module fifo_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_head_data,
  output logic [1:0]       o_occ
);

  logic [WIDTH-1:0] slot0_q;
  logic [WIDTH-1:0] slot1_q;
  logic [1:0]       occ_q;
  logic             do_rd;

  assign do_rd       = i_rd_en & (occ_q != 2'd0);
  assign o_head_data = slot0_q;
  assign o_occ       = occ_q;

  // slot0 is always the head; slot1 is the write slot behind it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      occ_q <= occ_q + 2'(i_wr_en) - 2'(do_rd);
      case ({i_wr_en, do_rd})
        2'b10: begin
          if (occ_q == 2'd0) slot0_q <= i_wr_data;
          else               slot1_q <= i_wr_data;
        end
        2'b01: slot0_q <= slot1_q;
        2'b11: begin
          // Head leaves while a word arrives: occupancy is unchanged.
          if (occ_q == 2'd1) begin
            slot0_q <= i_wr_data;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= i_wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for async_fifo: pops the FIFO read port and turns
// the registered read data into a valid/ready stream.
//   i_clk, i_rst_n : read-domain clock, asynchronous active-low reset
//   i_en           : allow new pops (buffered words drain regardless)
//   i_empty        : FIFO empty flag
//   o_pop          : FIFO pop strobe
//   i_rdata        : FIFO read data, valid the cycle after o_pop
//   o_valid/o_data : stream word, held while i_ready is low
//   i_ready        : consumer accept
//   o_level        : words held in the buffer (0..2)
//   o_rd_cnt       : words delivered since reset, wraps silently
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_empty,
  output logic             o_pop,
  input  logic [WIDTH-1:0] i_rdata,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       o_level,
  output logic [CNT_W-1:0] o_rd_cnt
);

  logic       infl_p0;
  logic       fire;
  logic [1:0] occ;
  logic [2:0] space;

  assign o_valid = (occ != 2'd0);
  assign fire    = o_valid & i_ready;
  assign o_level = occ;

  // A word leaving this cycle frees its slot for a pop issued this cycle,
  // which is what sustains one word per clock under continuous ready.
  assign space = calc_space(occ, infl_p0, fire);
  assign o_pop = i_rst_n & i_en & ~i_empty & (space != 3'd0);

  // Stage p0: pop issued last cycle, its read data is on i_rdata now.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      infl_p0  <= 1'b0;
      o_rd_cnt <= '0;
    end else begin
      infl_p0  <= o_pop;
      o_rd_cnt <= o_rd_cnt + CNT_W'(fire);
    end
  end

  // Stage p1: captured words are presented from the buffer head (no bypass).
  fifo_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wr_en     (infl_p0),
    .i_wr_data   (i_rdata),
    .i_rd_en     (fire),
    .o_head_data (o_data),
    .o_occ       (occ)
  );

  a_no_overcommit: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !((occ == 2'd2) && infl_p0) && (occ != 2'd3));

endmodule
